mdu_ctrl: RTL and testbench

//   Multi-cycle multiply/divide controller for MULT/MULTU/DIV/DIVU, decoded in the ID stage.
//   It sits beside the EX-stage ALU and accepts one operation at a time with operands rs/rt.
//   It sequences an iterative 32-step datapath and holds the pipeline through stallreq.
//   On completion it presents a one-cycle hi/lo result for the EX->MEM bus and the HI/LO write.

---
 rtl/mdu_ctrl_pkg.sv | 26 ++
 rtl/mdu_ctrl_core.sv | 75 +++++++
 rtl/mdu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// FSM state encoding, iteration count and a small magnitude helper.
package mdu_ctrl_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;

    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_RUN  = 2'd1,
        MDU_ST_DONE = 2'd2
    } mdu_state_e;

    // Magnitude of a two's-complement value when treated as signed,
    // otherwise the raw value. |0x80000000| stays 0x80000000 (read unsigned).
    function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] v,
                                                     input logic               is_signed);
        return (is_signed && v[MDU_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per cycle on a 2*WIDTH accumulator.
// Multiply: acc starts as {0, multiplier}, operand reg holds the multiplicand;
//           after WIDTH steps acc = product.
// Divide:   acc starts as {0, dividend}, operand reg holds the divisor;
//           after WIDTH steps acc = {remainder, quotient}.
module mdu_ctrl_core
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_next_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_upper;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;

    // Single iteration of the selected algorithm on the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_upper = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_upper >= {1'b0, m_q});
        // When div_ge holds the true difference is below 2^WIDTH, so the
        // wrapped low bits are exact.
        div_rem   = div_upper[WIDTH-1:0] - m_q;
        if (div_q) begin
            acc_step = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                              : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Load on start, advance on step, otherwise hold.
    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        div_d = div_q;
        if (start_i) begin
            div_d = is_div_i;
            acc_d = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
            m_d   = is_div_i ? b_i : a_i;
        end else if (step_i) begin
            acc_d = acc_step;
        end
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign acc_next_o = acc_step;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller. Owns the IDLE/RUN/DONE FSM,
// the iteration counter, sign bookkeeping, the pipeline stall request and
// the hi/lo result registers; the iterative arithmetic lives in mdu_ctrl_core.
//
// Handshake: op_valid is the request and ~stallreq acts as the ready. An op
// is taken in the IDLE cycle where op_valid=1 and flush=0; the requester holds
// op/src_a/src_b stable for as long as stallreq=1 and through the DONE cycle,
// and res_valid marks the single cycle in which hi/lo carry the new result.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stallreq,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, step, finish, div_zero;
    logic               op_is_div, op_is_signed;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_is_div    = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    assign op_is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);

    // Next-state, counter and datapath strobes; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        div_zero = 1'b0;
        if (flush) begin
            state_d = MDU_ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MDU_ST_IDLE: begin
                    if (op_valid) begin
                        accept = 1'b1;
                        cnt_d  = '0;
                        if (op_is_div && (src_b == '0)) begin
                            div_zero = 1'b1;
                            state_d  = MDU_ST_DONE;
                        end else begin
                            state_d  = MDU_ST_RUN;
                        end
                    end
                end
                MDU_ST_RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        finish  = 1'b1;
                        cnt_d   = '0;
                        state_d = MDU_ST_DONE;
                    end
                end
                MDU_ST_DONE: begin
                    // The completed instruction is still on op_valid here.
                    state_d = MDU_ST_IDLE;
                end
                default: begin
                    state_d = MDU_ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sign bookkeeping on accept and sign-corrected result capture.
    always_comb begin
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        is_div_d    = is_div_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_valid_d = finish | div_zero;
        prod_fix    = neg_res_q ? -acc_next : acc_next;
        quo_fix     = neg_res_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix     = neg_rem_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        if (accept) begin
            is_div_d  = op_is_div;
            neg_res_d = op_is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_d = op_is_signed & src_a[WIDTH-1];
        end
        if (div_zero) begin
            hi_d = src_a;
            lo_d = '1;
        end else if (finish) begin
            if (is_div_q) begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end else begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end
        end
    end

    // FSM state and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sign flags, result registers and the completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_div_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_valid_q <= 1'b0;
        end else begin
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            is_div_q    <= is_div_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_valid_q <= res_valid_d;
        end
    end

    mdu_ctrl_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept),
        .step_i     (step),
        .is_div_i   (op_is_div),
        .a_i        (mdu_abs(src_a, op_is_signed)),
        .b_i        (mdu_abs(src_b, op_is_signed)),
        .acc_next_o (acc_next)
    );

    assign stallreq    = ~rst & (((state_q == MDU_ST_IDLE) & op_valid & ~flush) |
                                 (state_q == MDU_ST_RUN));
    assign busy        = (state_q != MDU_ST_IDLE);
    assign res_valid   = res_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed hi/lo vectors, stall/latency
// windows, divide-by-zero, flush and reset abandonment.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        busy;
  logic        res_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mdu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .stallreq    (stallreq),
    .busy        (busy),
    .res_valid   (res_valid),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Issue one op at the next negedge, hold it until res_valid, then release.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string tag);
    int exp_lat;
    bit seen;
    logic [63:0] e;
    exp_lat = (o[1] && (b == 32'd0)) ? 1 : 33;
    exp_q.push_back({eh, el});
    @(negedge clk);
    op = o; src_a = a; src_b = b; op_valid = 1'b1;
    #1;
    chk({tag, "/stall_T"}, {63'd0, stallreq}, 64'd1);
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (res_valid) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        chk({tag, "/latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "/hilo"}, {hi, lo}, e);
        chk({tag, "/stall_done"}, {63'd0, stallreq}, 64'd0);
        break;
      end else if (k < exp_lat) begin
        chk({tag, "/stall_run"}, {63'd0, stallreq}, 64'd1);
      end
    end
    if (!seen) begin
      chk({tag, "/timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    op_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    op_valid = 1'b1;
    #1;
    chk("rst/busy", {63'd0, busy}, 64'd0);
    chk("rst/res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst/hilo", {hi, lo}, 64'd0);
    chk("rst/stallreq", {63'd0, stallreq}, 64'd0);
    chk("rst/state", {62'd0, dbg_state}, 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // divide and multiply vectors
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_min_m1");
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "div_m100_7");
    do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, "divu_max_1");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, "mult_m1_m1");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, "multu_max_max");
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
    do_op(2'b01, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, "multu_shift");
    do_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_5_0");
    do_op(2'b10, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, "div_neg_0");

    // flush at T+10 of a div; hi/lo must hold the divide-by-zero result
    @(negedge clk);
    op = 2'b10; src_a = 32'd1000; src_b = 32'd7; op_valid = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (res_valid) pulses++;
    end
    flush = 1'b1; op_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush/busy", {63'd0, busy}, 64'd0);
    chk("flush/res_valid", {63'd0, res_valid}, 64'd0);
    chk("flush/hilo_hold", {hi, lo}, {32'h8000_0001, 32'hFFFF_FFFF});
    chk("flush/no_pulse", 64'(pulses), 64'd0);
    do_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, "divu_after_flush");

    // reset at T+5 of a mult abandons it
    @(negedge clk);
    op = 2'b00; src_a = 32'd3; src_b = 32'd4; op_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; op_valid = 1'b0;
    #1;
    chk("midrst/stall_in_rst", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst/busy", {63'd0, busy}, 64'd0);
    chk("midrst/res_valid", {63'd0, res_valid}, 64'd0);
    chk("midrst/hilo", {hi, lo}, 64'd0);
    chk("midrst/stallreq", {63'd0, stallreq}, 64'd0);
    pulses = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      #1;
      if (res_valid) pulses++;
    end
    chk("midrst/no_pulse", 64'(pulses), 64'd0);

    // flush together with op_valid in IDLE must not accept
    @(negedge clk);
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; op_valid = 1'b1; flush = 1'b1;
    #1;
    chk("idleflush/stallreq", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    #1;
    chk("idleflush/busy", {63'd0, busy}, 64'd0);
    op_valid = 1'b0; flush = 1'b0;

    // back-to-back still works after all of the above
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6_7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
